mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/DMA) arbiter onto a single combinational-read memory port.
// Optional `define MEM_ARB_BOUNDS_EN rejects addresses beyond the 64-word memory and flags err.
module mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_we,
    output logic [31:0] m_a,
    output logic [31:0] m_wd,
    input  logic [31:0] m_rd,

    output logic        err
);

    localparam int CntW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e          state_q;
    logic            dmaWin_q;
    logic [CntW-1:0] waitCnt_q;
    logic [CntW-1:0] waitCnt_d;

    logic            c_gnt_q;
    logic            d_gnt_q;
    logic            c_rvalid_q;
    logic            d_rvalid_q;
    logic [31:0]     c_rdata_q;
    logic [31:0]     d_rdata_q;
    logic            m_we_q;
    logic [31:0]     m_a_q;
    logic [31:0]     m_wd_q;

    logic            anyReq;
    logic            dmaWins;
    logic            selWe;
    logic [31:0]     selAddr;
    logic [31:0]     selWdata;
    logic            launchWe;
    logic [31:0]     rdWord;

    // CPU has priority; the DMA is forced through once it has lost MAX_WAIT times in a row.
    always_comb begin
        anyReq    = c_req | d_req;
        dmaWins   = d_req & (~c_req | (waitCnt_q == MaxCnt));
        waitCnt_d = waitCnt_q;
        if (dmaWins) begin
            waitCnt_d = '0;
        end else if (c_req && d_req && (waitCnt_q != MaxCnt)) begin
            waitCnt_d = waitCnt_q + CntW'(1);
        end
        selWe    = dmaWins ? d_we    : c_we;
        selAddr  = dmaWins ? d_addr  : c_addr;
        selWdata = dmaWins ? d_wdata : c_wdata;
    end

`ifdef MEM_ARB_BOUNDS_EN
    logic oob_q;
    logic err_q;
    logic selOob;

    assign selOob   = |selAddr[31:8];
    assign launchWe = selWe & ~selOob;
    assign rdWord   = oob_q ? 32'h0 : m_rd;
    assign err      = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oob_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if ((state_q != BUSY) && anyReq) begin
                oob_q <= selOob;
            end
            if (state_q == BUSY) begin
                err_q <= oob_q;
            end
        end
    end
`else
    assign launchWe = selWe;
    assign rdWord   = m_rd;
    assign err      = 1'b0;
`endif

    // IDLE and RESP both arbitrate, so back-to-back traffic alternates BUSY/RESP without idling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            dmaWin_q   <= 1'b0;
            waitCnt_q  <= '0;
            c_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
            m_we_q     <= 1'b0;
            m_a_q      <= 32'h0;
            m_wd_q     <= 32'h0;
        end else begin
            c_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            m_we_q     <= 1'b0;
            case (state_q)
                IDLE, RESP: begin
                    if (anyReq) begin
                        state_q   <= BUSY;
                        dmaWin_q  <= dmaWins;
                        waitCnt_q <= waitCnt_d;
                        m_a_q     <= selAddr;
                        m_wd_q    <= selWdata;
                        m_we_q    <= launchWe;
                        c_gnt_q   <= ~dmaWins;
                        d_gnt_q   <= dmaWins;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    state_q <= RESP;
                    if (dmaWin_q) begin
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= rdWord;
                    end else begin
                        c_rvalid_q <= 1'b1;
                        c_rdata_q  <= rdWord;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c_gnt    = c_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_we     = m_we_q;
    assign m_a      = m_a_q;
    assign m_wd     = m_wd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
// Honours `define MEM_ARB_BOUNDS_EN the same way as the design.
module tb_mem_arbiter;

    localparam int MaxWait = 4;
`ifdef MEM_ARB_BOUNDS_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cReq, cWe, dReq, dWe;
    logic [31:0] cAddr, cWdata, dAddr, dWdata;
    logic        cGnt, cRvalid, dGnt, dRvalid;
    logic [31:0] cRdata, dRdata;
    logic        mWe;
    logic [31:0] mA, mWd, mRd;
    logic        errOut;

    mem_arbiter #(.MAX_WAIT(MaxWait)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .c_req    (cReq),
        .c_we     (cWe),
        .c_addr   (cAddr),
        .c_wdata  (cWdata),
        .c_gnt    (cGnt),
        .c_rvalid (cRvalid),
        .c_rdata  (cRdata),
        .d_req    (dReq),
        .d_we     (dWe),
        .d_addr   (dAddr),
        .d_wdata  (dWdata),
        .d_gnt    (dGnt),
        .d_rvalid (dRvalid),
        .d_rdata  (dRdata),
        .m_we     (mWe),
        .m_a      (mA),
        .m_wd     (mWd),
        .m_rd     (mRd),
        .err      (errOut)
    );

    always #5 clk = ~clk;

    // Environment memory seen by the DUT; the model keeps its own copy in refMem.
    logic [31:0] initMem [64];
    logic [31:0] envMem  [64];
    logic [31:0] refMem  [64];
    logic        memLoad;

    always @(posedge clk) begin
        if (memLoad) begin
            for (int i = 0; i < 64; i++) envMem[i] <= initMem[i];
        end else if (mWe) begin
            envMem[mA[7:2]] <= mWd;
        end
    end

    assign mRd = envMem[mA[7:2]];

    int          numChecks = 0;
    int          numErrors = 0;
    int          grantsSeen, dGrantsSeen;
    logic        prevCReq, prevCWe, prevDReq, prevDWe;
    logic [31:0] prevCAddr, prevCWdata, prevDAddr, prevDWdata;
    logic        sawCGnt, sawDGnt;
    int          grantPrev;
    int          lossCount;
    logic [31:0] expMA, expMWd, expCRdata, expDRdata, rspData;
    logic        rspErr;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        prevCReq = 1'b0; prevCWe = 1'b0; prevCAddr = 32'h0; prevCWdata = 32'h0;
        prevDReq = 1'b0; prevDWe = 1'b0; prevDAddr = 32'h0; prevDWdata = 32'h0;
        sawCGnt = 1'b0; sawDGnt = 1'b0;
        grantPrev = 0; lossCount = 0;
        expMA = 32'h0; expMWd = 32'h0; expCRdata = 32'h0; expDRdata = 32'h0;
        rspData = 32'h0; rspErr = 1'b0;
    endtask

    task automatic randomTxn(output logic we, output logic [31:0] addr, output logic [31:0] wdata);
        we = 1'($urandom_range(1));
        if ($urandom_range(7) == 0) addr = $urandom | 32'h100;
        else                        addr = 32'($urandom_range(63)) << 2;
        wdata = $urandom;
    endtask

    // Each requester holds its request until granted, then may issue a new one next cycle.
    task automatic applyStimulus(input int probC, input int probD);
        if (cReq && sawCGnt) cReq = 1'b0;
        if (dReq && sawDGnt) dReq = 1'b0;
        if (!cReq && int'($urandom_range(99)) < probC) begin
            randomTxn(cWe, cAddr, cWdata);
            cReq = 1'b1;
        end
        if (!dReq && int'($urandom_range(99)) < probD) begin
            randomTxn(dWe, dAddr, dWdata);
            dReq = 1'b1;
        end
    endtask

    // One cycle of the reference: a grant follows any request seen in a non-grant cycle,
    // and the response follows every grant by one cycle.
    task automatic modelStep();
        logic        expCGnt, expDGnt, expCRv, expDRv, expErr, expMWe;
        logic        gWe, oob;
        logic [31:0] gAddr, gWdata;
        int          who;
        expCRv = 1'b0; expDRv = 1'b0; expErr = 1'b0;
        if (grantPrev == 1) begin expCRv = 1'b1; expCRdata = rspData; expErr = rspErr; end
        if (grantPrev == 2) begin expDRv = 1'b1; expDRdata = rspData; expErr = rspErr; end
        expCGnt = 1'b0; expDGnt = 1'b0; expMWe = 1'b0; who = 0;
        if (grantPrev == 0 && (prevCReq || prevDReq)) begin
            if (prevDReq && (!prevCReq || lossCount >= MaxWait)) begin
                who = 2; lossCount = 0;
                gWe = prevDWe; gAddr = prevDAddr; gWdata = prevDWdata;
            end else begin
                who = 1;
                if (prevDReq && lossCount < MaxWait) lossCount++;
                gWe = prevCWe; gAddr = prevCAddr; gWdata = prevCWdata;
            end
            oob = BoundsEn && (gAddr[31:8] != 24'h0);
            expCGnt = (who == 1);
            expDGnt = (who == 2);
            expMA   = gAddr;
            expMWd  = gWdata;
            expMWe  = gWe && !oob;
            rspData = oob ? 32'h0 : refMem[gAddr[7:2]];
            rspErr  = oob;
            if (expMWe) refMem[gAddr[7:2]] = gWdata;
        end
        grantPrev = who;

        checkOutput("cGnt",      32'(cGnt),    32'(expCGnt));
        checkOutput("dGnt",      32'(dGnt),    32'(expDGnt));
        checkOutput("cRvalid",   32'(cRvalid), 32'(expCRv));
        checkOutput("dRvalid",   32'(dRvalid), 32'(expDRv));
        checkOutput("cRdata",    cRdata,       expCRdata);
        checkOutput("dRdata",    dRdata,       expDRdata);
        checkOutput("mWe",       32'(mWe),     32'(expMWe));
        checkOutput("mA",        mA,           expMA);
        checkOutput("mWd",       mWd,          expMWd);
        checkOutput("err",       32'(errOut),  32'(expErr));
        checkOutput("gntExcl",   32'(cGnt & dGnt),       32'h0);
        checkOutput("rvalidExcl",32'(cRvalid & dRvalid), 32'h0);

        prevCReq = cReq; prevCWe = cWe; prevCAddr = cAddr; prevCWdata = cWdata;
        prevDReq = dReq; prevDWe = dWe; prevDAddr = dAddr; prevDWdata = dWdata;
        sawCGnt = cGnt; sawDGnt = dGnt;
        if (cGnt || dGnt) grantsSeen++;
        if (dGnt) dGrantsSeen++;
    endtask

    task automatic runCycles(input int n, input int probC, input int probD);
        for (int i = 0; i < n; i++) begin
            applyStimulus(probC, probD);
            @(negedge clk);
            modelStep();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetOutputs(input string prefix);
        checkOutput({prefix, "_cGnt"},    32'(cGnt),    32'h0);
        checkOutput({prefix, "_dGnt"},    32'(dGnt),    32'h0);
        checkOutput({prefix, "_cRvalid"}, 32'(cRvalid), 32'h0);
        checkOutput({prefix, "_dRvalid"}, 32'(dRvalid), 32'h0);
        checkOutput({prefix, "_cRdata"},  cRdata,       32'h0);
        checkOutput({prefix, "_dRdata"},  dRdata,       32'h0);
        checkOutput({prefix, "_mWe"},     32'(mWe),     32'h0);
        checkOutput({prefix, "_mA"},      mA,           32'h0);
        checkOutput({prefix, "_mWd"},     mWd,          32'h0);
        checkOutput({prefix, "_err"},     32'(errOut),  32'h0);
    endtask

    // Start a CPU write, pull reset during its BUSY cycle and confirm nothing is written.
    task automatic resetMidAccess();
        runCycles(12, 0, 0);
        dReq = 1'b0;
        cReq = 1'b1; cWe = 1'b1; cAddr = 32'h20; cWdata = $urandom;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstBusyGnt", 32'(cGnt), 32'h1);
        checkOutput("rstBusyWe",  32'(mWe),  32'h1);
        reset_n = 1'b0;
        #1;
        checkResetOutputs("rstMid");
        @(posedge clk);
        #1;
        checkOutput("rstNoWrite", envMem[8], refMem[8]);
        cReq = 1'b0; cWe = 1'b0;
        @(posedge clk);
        #1;
        checkResetOutputs("rstHeld");
        reset_n = 1'b1;
        resetModel();
    endtask

    initial begin
        reset_n = 1'b0;
        memLoad = 1'b1;
        cReq = 1'b0; cWe = 1'b0; cAddr = 32'h0; cWdata = 32'h0;
        dReq = 1'b0; dWe = 1'b0; dAddr = 32'h0; dWdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            initMem[i] = $urandom;
            refMem[i]  = initMem[i];
        end
        resetModel();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("init");
        @(posedge clk);
        #1;
        memLoad = 1'b0;
        reset_n = 1'b1;

        // Both requesters saturated from reset: grant order C,C,C,C,D repeating.
        grantsSeen = 0;
        dGrantsSeen = 0;
        runCycles(100, 100, 100);
        checkOutput("starveGrants",  32'(grantsSeen),  32'd50);
        checkOutput("starveDGrants", 32'(dGrantsSeen), 32'd10);

        runCycles(300, 60, 40);
        resetMidAccess();
        runCycles(200, 30, 70);
        runCycles(100, 100, 20);

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
        $finish;
    end

endmodule
